id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline boundary of the 5-stage RV32 core. It captures the decoded instruction and its operands at the end of ID. It applies the hazard unit's `stall` by inserting a bubble into EX, and applies the hazard unit's forwarding selects to resolve source operands before registering them. It also honours an EX-stage branch flush and keeps saturating stall/flush event counters for performance debug.

## Interface
- Clock/reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- Parameters:
  - `XLEN`, 32, datapath width
  - `CNT_W`, 16, width of event counters
- Ports:
  - `clk` in 1: core clock
  - `rst` in 1: synchronous active-high reset
  - `id_valid` in 1: ID holds a real instruction
  - `id_pc` in XLEN: PC of the ID instruction
  - `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices
  - `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data
  - `id_imm` in XLEN: decoded immediate
  - `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_alu_src` in 1 each: control bits
  - `id_alu_op` in 4: ALU operation
  - `stall` in 1: load-use stall from hazard unit
  - `forward_a`, `forward_b` in 1 each: forwarding enables
  - `forward_a_src`, `forward_b_src` in 2 each: 01 = EX result, 10 = MEM result
  - `ex_result` in XLEN: ALU result of the instruction currently in EX
  - `mem_result` in XLEN: writeback value of the instruction currently in MEM
  - `flush` in 1: branch/jump taken in EX; kill ID
  - `ex_valid` out 1, `ex_pc` out XLEN, `ex_rd` out 5
  - `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_alu_src` out 1 each
  - `ex_alu_op` out 4
  - `ex_op_a`, `ex_op_b` out XLEN: resolved rs1/rs2 values
  - `ex_imm` out XLEN
  - `stall_count`, `flush_count` out CNT_W: saturating event counters

## Operation
- Every output is a register updated on the rising edge of `clk`. There is no combinational input-to-output path.
- Operand resolution, shown for A; B is identical using rs2:
  - `forward_a`=1 and src=01 → `ex_result`
  - `forward_a`=1 and src=10 → `mem_result`
  - `forward_a`=0, or src ∈ {00,11} → `id_rs1_data`
- Operand resolution follows src exactly; the block does not second-guess the hazard unit's priority.
- Capture priority each cycle is `rst` > `flush` > `stall` > normal load.
- **Bubble** (on `flush` or `stall`):
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` are set to 0.
  - `ex_rd` is set to 0, so the hazard unit sees no match.
  - `ex_alu_op`, `ex_alu_src`, `ex_op_a`, `ex_op_b`, `ex_imm`, `ex_pc` are set to 0.
- **Normal load**:
  - All fields are captured from ID.
  - Control bits are ANDed with `id_valid`.
  - `ex_reg_write` is forced to 0 when `id_rd`=0.
- The block does not hold PC or IF/ID. Upstream stages consume `stall` themselves.
- **Counters**:
  - `stall_count` increments on each cycle with `stall`=1 and `flush`=0.
  - `flush_count` increments on each cycle with `flush`=1.
  - Both saturate at all-ones and never wrap.
  - Both clear only on `rst`.

## Timing
- Latency is 1 cycle, ID to EX registers.
- Forward data is sampled in the same cycle as the forward selects.
- Reset values: all outputs, including both counters, are 0. `ex_valid`=0.
- `rst` asserted mid-stream: the next edge produces a bubble and zeroed counters, regardless of `flush`/`stall`.
- `flush` and `stall` asserted together: one bubble. Only `flush_count` increments.
- Consecutive `stall` cycles: one bubble per cycle, and `stall_count` increments each cycle.
- `id_valid`=0 with no stall: registers load, but all control bits are 0 (behaves as a bubble); no counter changes.
- Both operands may forward from the same source in the same cycle.

## Test plan
- **Reset**: assert `rst` 2 cycles with random inputs → all outputs 0 on the following edge.
- **Forward EX**:
  - Stimulus: `id_rs1_data`=0x11, `ex_result`=0xAAAA0001, `forward_a`=1, src=01.
  - Required: `ex_op_a`=0xAAAA0001, `ex_valid`=1.
- **Forward MEM**:
  - Stimulus: `forward_b`=1, src=10, `mem_result`=0x5555; separately, src=11 with `id_rs2_data`=0x7.
  - Required: `ex_op_b`=0x5555 for the first case; `ex_op_b`=0x7 for src=11.
- **Stall**:
  - Stimulus: `stall`=1 for 3 cycles with a load instruction in ID (`id_rd`=5).
  - Required: `ex_valid`=0, `ex_rd`=0, `ex_mem_read`=0 for 3 cycles; `stall_count`=3.
- **Flush priority**:
  - Stimulus: `flush`=1 and `stall`=1 together.
  - Required: bubble; `flush_count`=1, `stall_count` unchanged. Also `id_rd`=0 with `id_reg_write`=1 → `ex_reg_write`=0.
- **Saturation**:
  - Stimulus: `CNT_W`=4, hold `stall` for 20 cycles.
  - Required: `stall_count` holds at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands, inserts bubbles on
// stall/flush, and keeps saturating stall/flush event counters.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_alu_src,
   input  logic [3:0]       id_alu_op,
   input  logic             stall,
   input  logic             forward_a,
   input  logic             forward_b,
   input  logic [1:0]       forward_a_src,
   input  logic [1:0]       forward_b_src,
   input  logic [XLEN-1:0]  ex_result,
   input  logic [XLEN-1:0]  mem_result,
   input  logic             flush,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_alu_src,
   output logic [3:0]       ex_alu_op,
   output logic [XLEN-1:0]  ex_op_a,
   output logic [XLEN-1:0]  ex_op_b,
   output logic [XLEN-1:0]  ex_imm,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   logic [XLEN-1:0] op_a, op_b;
   logic            bubble;

   // Selects are honoured literally; src 00/11 fall back to the register file.
   always_comb begin
      op_a = id_rs1_data;
      if (forward_a && forward_a_src == 2'b01)      op_a = ex_result;
      else if (forward_a && forward_a_src == 2'b10) op_a = mem_result;
      op_b = id_rs2_data;
      if (forward_b && forward_b_src == 2'b01)      op_b = ex_result;
      else if (forward_b && forward_b_src == 2'b10) op_b = mem_result;
   end

   assign bubble = flush | stall;

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_alu_op    <= '0;
         ex_op_a      <= '0;
         ex_op_b      <= '0;
         ex_imm       <= '0;
      end else begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_rd        <= id_rd;
         // x0 writes are dropped here so downstream hazard checks never match rd=0
         ex_reg_write <= id_valid & id_reg_write & (id_rd != 5'd0);
         ex_mem_read  <= id_valid & id_mem_read;
         ex_mem_write <= id_valid & id_mem_write;
         ex_alu_src   <= id_valid & id_alu_src;
         ex_alu_op    <= id_valid ? id_alu_op : 4'd0;
         ex_op_a      <= op_a;
         ex_op_b      <= op_b;
         ex_imm       <= id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (flush && flush_count != '1)
            flush_count <= flush_count + 1'b1;
         if (stall && !flush && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with CNT_W=4 checks saturation.
module tb_id_ex_stage;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
   logic            id_reg_write, id_mem_read, id_mem_write, id_alu_src;
   logic [3:0]      id_alu_op;
   logic            stall, forward_a, forward_b, flush;
   logic [1:0]      forward_a_src, forward_b_src;
   logic [XLEN-1:0] ex_result, mem_result;

   logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
   logic [XLEN-1:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
   logic [4:0]      ex_rd;
   logic [3:0]      ex_alu_op;
   logic [15:0]     stall_count, flush_count;

   logic            s_valid, s_reg_write, s_mem_read, s_mem_write, s_alu_src;
   logic [XLEN-1:0] s_pc, s_op_a, s_op_b, s_imm;
   logic [4:0]      s_rd;
   logic [3:0]      s_alu_op;
   logic [3:0]      s_stall_count, s_flush_count;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .stall(stall), .forward_a(forward_a), .forward_b(forward_b),
      .forward_a_src(forward_a_src), .forward_b_src(forward_b_src),
      .ex_result(ex_result), .mem_result(mem_result), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .stall(stall), .forward_a(forward_a), .forward_b(forward_b),
      .forward_a_src(forward_a_src), .forward_b_src(forward_b_src),
      .ex_result(ex_result), .mem_result(mem_result), .flush(flush),
      .ex_valid(s_valid), .ex_pc(s_pc), .ex_rd(s_rd),
      .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read),
      .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src), .ex_alu_op(s_alu_op),
      .ex_op_a(s_op_a), .ex_op_b(s_op_b), .ex_imm(s_imm),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
      chk({tag, ".rd"}, {27'd0, ex_rd}, 32'd0);
      chk({tag, ".ctl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src}, 32'd0);
      chk({tag, ".alu_op"}, {28'd0, ex_alu_op}, 32'd0);
      chk({tag, ".op_a"}, ex_op_a, 32'd0);
      chk({tag, ".op_b"}, ex_op_b, 32'd0);
      chk({tag, ".imm"}, ex_imm, 32'd0);
      chk({tag, ".pc"}, ex_pc, 32'd0);
   endtask

   task automatic drive_default();
      id_valid = 1'b1; id_pc = 32'h100;
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
      id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_imm = 32'h44;
      id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
      id_alu_src = 1'b0; id_alu_op = 4'h2;
      stall = 1'b0; flush = 1'b0;
      forward_a = 1'b0; forward_b = 1'b0;
      forward_a_src = 2'b00; forward_b_src = 2'b00;
      ex_result = 32'hAAAA0001; mem_result = 32'h5555;
   endtask

   initial begin
      // reset with random inputs
      rst = 1'b1;
      id_valid = 1'b1; id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_rd = 5'd7; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_alu_src = 1'b1;
      id_alu_op = 4'hF; stall = 1'($urandom); flush = 1'($urandom);
      forward_a = 1'b1; forward_b = 1'b1; forward_a_src = 2'b01; forward_b_src = 2'b10;
      ex_result = $urandom; mem_result = $urandom;
      step(); step();
      chk_bubble("reset");
      chk("reset.stall_cnt", {16'd0, stall_count}, 32'd0);
      chk("reset.flush_cnt", {16'd0, flush_count}, 32'd0);

      // forward A from EX
      rst = 1'b0;
      drive_default();
      forward_a = 1'b1; forward_a_src = 2'b01;
      step();
      chk("fwd_ex.op_a", ex_op_a, 32'hAAAA0001);
      chk("fwd_ex.valid", {31'd0, ex_valid}, 32'd1);
      chk("fwd_ex.op_b", ex_op_b, 32'h22);
      chk("fwd_ex.rd", {27'd0, ex_rd}, 32'd3);
      chk("fwd_ex.reg_write", {31'd0, ex_reg_write}, 32'd1);
      chk("fwd_ex.pc", ex_pc, 32'h100);
      chk("fwd_ex.alu_op", {28'd0, ex_alu_op}, 32'h2);
      chk("fwd_ex.imm", ex_imm, 32'h44);

      // forward B from MEM, then src=11 falls back to register file
      drive_default();
      forward_b = 1'b1; forward_b_src = 2'b10;
      step();
      chk("fwd_mem.op_b", ex_op_b, 32'h5555);
      chk("fwd_mem.op_a", ex_op_a, 32'h11);
      id_rs2_data = 32'h7; forward_b_src = 2'b11;
      step();
      chk("fwd_src11.op_b", ex_op_b, 32'h7);
      // forward enabled with src=00 also uses register data
      forward_b_src = 2'b00; forward_a = 1'b1; forward_a_src = 2'b00;
      step();
      chk("fwd_src00.op_a", ex_op_a, 32'h11);
      chk("fwd_src00.op_b", ex_op_b, 32'h7);

      // both operands from the same source
      forward_a = 1'b1; forward_a_src = 2'b10; forward_b = 1'b1; forward_b_src = 2'b10;
      step();
      chk("fwd_both.op_a", ex_op_a, 32'h5555);
      chk("fwd_both.op_b", ex_op_b, 32'h5555);

      // three stall cycles with a load in ID
      drive_default();
      id_rd = 5'd5; id_mem_read = 1'b1; id_alu_src = 1'b1; stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk_bubble("stall");
         chk("stall.stall_cnt", {16'd0, stall_count}, i);
      end
      chk("stall.flush_cnt", {16'd0, flush_count}, 32'd0);

      // flush and stall together: one bubble, only flush counted
      flush = 1'b1;
      step();
      chk_bubble("flush");
      chk("flush.flush_cnt", {16'd0, flush_count}, 32'd1);
      chk("flush.stall_cnt", {16'd0, stall_count}, 32'd3);

      // rd=0 suppresses reg_write
      drive_default();
      id_rd = 5'd0;
      step();
      chk("rd0.reg_write", {31'd0, ex_reg_write}, 32'd0);
      chk("rd0.valid", {31'd0, ex_valid}, 32'd1);

      // id_valid=0: fields load, control bits are zero, counters unchanged
      drive_default();
      id_valid = 1'b0; id_mem_read = 1'b1; id_mem_write = 1'b1; id_alu_src = 1'b1;
      step();
      chk("inv.valid", {31'd0, ex_valid}, 32'd0);
      chk("inv.ctl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src}, 32'd0);
      chk("inv.alu_op", {28'd0, ex_alu_op}, 32'd0);
      chk("inv.pc", ex_pc, 32'h100);
      chk("inv.stall_cnt", {16'd0, stall_count}, 32'd3);
      chk("inv.flush_cnt", {16'd0, flush_count}, 32'd1);

      // saturation: narrow instance already holds 3 stalls, 20 more pins it at 15
      drive_default();
      stall = 1'b1;
      repeat (20) step();
      chk("sat.stall_cnt4", {28'd0, s_stall_count}, 32'd15);
      chk("sat.stall_cnt16", {16'd0, stall_count}, 32'd23);
      step();
      chk("sat.hold", {28'd0, s_stall_count}, 32'd15);
      stall = 1'b0; flush = 1'b1;
      repeat (16) step();
      chk("sat.flush_cnt4", {28'd0, s_flush_count}, 32'd15);

      // reset mid-stream wins over flush/stall
      drive_default();
      step();
      chk("pre_rst.valid", {31'd0, ex_valid}, 32'd1);
      rst = 1'b1; flush = 1'b1; stall = 1'b1;
      step();
      chk_bubble("mid_rst");
      chk("mid_rst.stall_cnt", {16'd0, stall_count}, 32'd0);
      chk("mid_rst.flush_cnt", {16'd0, flush_count}, 32'd0);
      rst = 1'b0; flush = 1'b0; stall = 1'b0;
      step();
      chk("post_rst.valid", {31'd0, ex_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
